// File: rtl/niosii_dual_port_tcm_if.sv
// Avalon-MM slave port bundle for one side of the dual-port TCM.
interface niosii_dual_port_tcm_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/niosii_dual_port_tcm.sv
// Dual-port tightly coupled memory with optional zero-fill after reset,
// byte-lane writes, pipelined reads and port-A priority on write collisions.
module niosii_dual_port_tcm #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  niosii_dual_port_tcm_if.slave port_a,
  niosii_dual_port_tcm_if.slave port_b,
  output logic                  init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  // Asynchronous assertion, clk-synchronous release.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Port 0 is A, port 1 is B.
  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [NB-1:0]         w_be    [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];
  logic                  w_cs    [2];
  logic                  w_rd    [2];
  logic                  w_wr    [2];
  logic                  w_wait  [2];
  logic                  w_acc   [2];
  logic                  w_wr_acc[2];
  logic                  w_rd_acc[2];
  logic                  w_collide;
  logic                  w_clearing;

  assign w_addr[0]  = port_a.address;
  assign w_addr[1]  = port_b.address;
  assign w_be[0]    = port_a.byteenable;
  assign w_be[1]    = port_b.byteenable;
  assign w_wdata[0] = port_a.writedata;
  assign w_wdata[1] = port_b.writedata;
  assign w_cs[0]    = port_a.chipselect;
  assign w_cs[1]    = port_b.chipselect;
  assign w_rd[0]    = port_a.read;
  assign w_rd[1]    = port_b.read;
  assign w_wr[0]    = port_a.write;
  assign w_wr[1]    = port_b.write;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;
  logic                  r_init_done;

  // B is stalled for one cycle when both ports write the same word; A wins.
  assign w_collide = r_init_done & w_cs[0] & w_wr[0] & w_cs[1] & w_wr[1] &
                     (w_addr[0] == w_addr[1]);

  assign w_wait[0] = ~r_init_done;
  assign w_wait[1] = ~r_init_done | w_collide;

  genvar gp;
  generate
    for (gp = 0; gp < 2; gp++) begin : g_port
      assign w_acc[gp]    = w_cs[gp] & (w_rd[gp] | w_wr[gp]) & ~w_wait[gp];
      assign w_wr_acc[gp] = w_acc[gp] & w_wr[gp];
      assign w_rd_acc[gp] = w_acc[gp] & w_rd[gp] & ~w_wr[gp];
    end
  endgenerate

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clear_cnt <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clear_cnt <= r_clear_cnt + 1'b1;
          if (r_clear_cnt == '1) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        ST_READY: r_init_done <= 1'b1;
        default: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  assign w_clearing = (r_state == ST_CLEAR) & w_rst_n;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Port B is applied first so port A would take precedence on a shared word.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_clear_cnt] <= '0;
    end else begin
      for (int unsigned q = 0; q < 2; q++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (w_wr_acc[1-q] && w_be[1-q][b])
            r_mem[w_addr[1-q]][b*8 +: 8] <= w_wdata[1-q][b*8 +: 8];
        end
      end
    end
  end

  // Stage 0 samples the array on acceptance (old data on a same-edge write);
  // stage 1 only matters for two-cycle latency. Data registers hold when idle.
  logic                  r_s0_vld[2];
  logic                  r_s1_vld[2];
  logic [DATA_WIDTH-1:0] r_s0_dat[2];
  logic [DATA_WIDTH-1:0] r_s1_dat[2];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_s0_vld[p] <= 1'b0;
        r_s1_vld[p] <= 1'b0;
        r_s0_dat[p] <= '0;
        r_s1_dat[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_s0_vld[p] <= w_rd_acc[p];
        if (w_rd_acc[p]) r_s0_dat[p] <= r_mem[w_addr[p]];
        r_s1_vld[p] <= r_s0_vld[p];
        if (r_s0_vld[p]) r_s1_dat[p] <= r_s0_dat[p];
      end
    end
  end

  assign port_a.readdata      = (READ_LATENCY == 2) ? r_s1_dat[0] : r_s0_dat[0];
  assign port_b.readdata      = (READ_LATENCY == 2) ? r_s1_dat[1] : r_s0_dat[1];
  assign port_a.readdatavalid = (READ_LATENCY == 2) ? r_s1_vld[0] : r_s0_vld[0];
  assign port_b.readdatavalid = (READ_LATENCY == 2) ? r_s1_vld[1] : r_s0_vld[1];
  assign port_a.waitrequest   = w_wait[0];
  assign port_b.waitrequest   = w_wait[1];
  assign init_done            = r_init_done;

endmodule

// File: tb/tb_niosii_dual_port_tcm.sv
// Bench: two TCM instances (read latency 1 and 2) driven with identical
// stimulus and checked against a word-array reference with timed read slots.
module tb_niosii_dual_port_tcm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic done1, done2;

  niosii_dual_port_tcm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) a1 ();
  niosii_dual_port_tcm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) b1 ();
  niosii_dual_port_tcm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) a2 ();
  niosii_dual_port_tcm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) b2 ();

  niosii_dual_port_tcm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .port_a(a1.slave), .port_b(b1.slave), .init_done(done1)
  );

  niosii_dual_port_tcm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .port_a(a2.slave), .port_b(b2.slave), .init_done(done2)
  );

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [11:0] ad;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: word array plus expected-read slots keyed by cycle (mod 8).
  // Index 0=dut1 A, 1=dut1 B, 2=dut2 A, 3=dut2 B.
  logic [31:0] m_mem [4096];
  bit          ev    [4][8];
  logic [31:0] ed    [4][8];
  logic [31:0] last_d[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic req_t mk(input logic cs, input logic rd, input logic wr,
                              input logic [11:0] ad, input logic [3:0] be,
                              input logic [31:0] wd);
    req_t r;
    r.cs = cs; r.rd = rd; r.wr = wr; r.ad = ad; r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic req_t wr_req(input logic [11:0] ad, input logic [31:0] wd,
                                  input logic [3:0] be);
    return mk(1'b1, 1'b0, 1'b1, ad, be, wd);
  endfunction

  function automatic req_t rd_req(input logic [11:0] ad);
    return mk(1'b1, 1'b1, 1'b0, ad, 4'h0, 32'h0);
  endfunction

  localparam req_t IDLE = '0;

  task automatic drive(input req_t ra, input req_t rb);
    a1.chipselect = ra.cs; a1.read = ra.rd; a1.write = ra.wr;
    a1.address = ra.ad; a1.byteenable = ra.be; a1.writedata = ra.wd;
    a2.chipselect = ra.cs; a2.read = ra.rd; a2.write = ra.wr;
    a2.address = ra.ad; a2.byteenable = ra.be; a2.writedata = ra.wd;
    b1.chipselect = rb.cs; b1.read = rb.rd; b1.write = rb.wr;
    b1.address = rb.ad; b1.byteenable = rb.be; b1.writedata = rb.wd;
    b2.chipselect = rb.cs; b2.read = rb.rd; b2.write = rb.wr;
    b2.address = rb.ad; b2.byteenable = rb.be; b2.writedata = rb.wd;
  endtask

  task automatic check_reads;
    logic [3:0]  av;
    logic [31:0] adat[4];
    int          s;
    s = cyc & 7;
    av = {b2.readdatavalid, a2.readdatavalid, b1.readdatavalid, a1.readdatavalid};
    adat[0] = a1.readdata; adat[1] = b1.readdata;
    adat[2] = a2.readdata; adat[3] = b2.readdata;
    for (int i = 0; i < 4; i++) begin
      if (ev[i][s]) last_d[i] = ed[i][s];
      chk($sformatf("rdvalid[%0d]", i), {31'b0, av[i]}, {31'b0, ev[i][s]});
      chk($sformatf("rdata[%0d]", i), adat[i], last_d[i]);
      ev[i][s] = 1'b0;
    end
  endtask

  // Called at a negedge; the request is taken at the following posedge.
  task automatic step(input req_t ra, input req_t rb);
    logic ewb, acca, accb;
    int   s1, s2;
    check_reads();
    drive(ra, rb);
    #1;
    ewb = ra.cs & ra.wr & rb.cs & rb.wr & (ra.ad == rb.ad);
    chk("wait_a1", {31'b0, a1.waitrequest}, 32'h0);
    chk("wait_a2", {31'b0, a2.waitrequest}, 32'h0);
    chk("wait_b1", {31'b0, b1.waitrequest}, {31'b0, ewb});
    chk("wait_b2", {31'b0, b2.waitrequest}, {31'b0, ewb});
    acca = ra.cs & (ra.rd | ra.wr);
    accb = rb.cs & (rb.rd | rb.wr) & ~ewb;
    s1 = (cyc + 1) & 7;
    s2 = (cyc + 2) & 7;
    if (acca && ra.rd && !ra.wr) begin
      ev[0][s1] = 1'b1; ed[0][s1] = m_mem[ra.ad];
      ev[2][s2] = 1'b1; ed[2][s2] = m_mem[ra.ad];
    end
    if (accb && rb.rd && !rb.wr) begin
      ev[1][s1] = 1'b1; ed[1][s1] = m_mem[rb.ad];
      ev[3][s2] = 1'b1; ed[3][s2] = m_mem[rb.ad];
    end
    if (acca && ra.wr) m_mem[ra.ad] = merge(m_mem[ra.ad], ra.wd, ra.be);
    if (accb && rb.wr) m_mem[rb.ad] = merge(m_mem[rb.ad], rb.wd, rb.be);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset;
    reset_n = 1'b0;
    drive(IDLE, IDLE);
    #1;
    chk("rst_done1", {31'b0, done1}, 32'h0);
    chk("rst_done2", {31'b0, done2}, 32'h0);
    chk("rst_wait_a1", {31'b0, a1.waitrequest}, 32'h1);
    chk("rst_wait_b1", {31'b0, b1.waitrequest}, 32'h1);
    chk("rst_wait_a2", {31'b0, a2.waitrequest}, 32'h1);
    chk("rst_wait_b2", {31'b0, b2.waitrequest}, 32'h1);
    chk("rst_rdv_a1", {31'b0, a1.readdatavalid}, 32'h0);
    chk("rst_rdv_b1", {31'b0, b1.readdatavalid}, 32'h0);
    chk("rst_rdv_a2", {31'b0, a2.readdatavalid}, 32'h0);
    chk("rst_rdv_b2", {31'b0, b2.readdatavalid}, 32'h0);
    chk("rst_rd_a1", a1.readdata, 32'h0);
    chk("rst_rd_b1", b1.readdata, 32'h0);
    chk("rst_rd_a2", a2.readdata, 32'h0);
    chk("rst_rd_b2", b2.readdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      last_d[i] = 32'h0;
      for (int j = 0; j < 8; j++) ev[i][j] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) m_mem[i] = 32'h0;
  endtask

  // 2 synchroniser edges + 4096 clear edges before init_done is seen.
  task automatic release_and_wait;
    int n;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!done1 && n < 6000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("init_cycles", n, 32'd4098);
    chk("init_done2", {31'b0, done2}, 32'h1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(IDLE, IDLE);
    repeat (3) @(negedge clk);
    assert_reset();
    release_and_wait();

    // Cleared top word reads back as zero.
    step(rd_req(12'hFFF), IDLE);
    chk("clr_fff_v", {31'b0, a1.readdatavalid}, 32'h1);
    chk("clr_fff_d", a1.readdata, 32'h0);

    // Byte-lane merge, read on the other port.
    step(wr_req(12'd5, 32'hAABBCCDD, 4'b1111), IDLE);
    step(wr_req(12'd5, 32'h11223344, 4'b0101), IDLE);
    step(IDLE, rd_req(12'd5));
    chk("byte_v", {31'b0, b1.readdatavalid}, 32'h1);
    chk("byte_d", b1.readdata, 32'hAA22CC44);

    // Same-address write collision, B held one more cycle.
    step(wr_req(12'd9, 32'h1, 4'hF), wr_req(12'd9, 32'h2, 4'hF));
    step(IDLE, wr_req(12'd9, 32'h2, 4'hF));
    step(rd_req(12'd9), IDLE);
    chk("coll_d", a1.readdata, 32'h2);

    // Read on B concurrent with A write to the same word.
    step(wr_req(12'd3, 32'h55, 4'hF), rd_req(12'd3));
    chk("rw_old", b1.readdata, 32'h0);
    step(IDLE, rd_req(12'd3));
    chk("rw_new", b1.readdata, 32'h55);

    // Back-to-back reads through the two-cycle pipeline.
    for (int i = 0; i < 8; i++) step(wr_req(12'(i), 32'hC0DE0000 | i, 4'hF), IDLE);
    for (int i = 0; i < 8; i++) begin
      step(IDLE, rd_req(12'(i)));
      if (i == 0) begin
        chk("pipe_v0", {31'b0, b2.readdatavalid}, 32'h0);
      end else begin
        chk("pipe_v", {31'b0, b2.readdatavalid}, 32'h1);
        chk("pipe_d", b2.readdata, 32'hC0DE0000 | (i - 1));
      end
    end
    step(IDLE, IDLE);
    chk("pipe_v7", {31'b0, b2.readdatavalid}, 32'h1);
    chk("pipe_d7", b2.readdata, 32'hC0DE0007);
    step(IDLE, IDLE);
    chk("pipe_end", {31'b0, b2.readdatavalid}, 32'h0);

    // Random traffic on a small address window to provoke collisions.
    for (int k = 0; k < 500; k++) begin
      req_t ra, rb;
      ra = mk($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
              12'($urandom_range(0, 15)), 4'($urandom), $urandom);
      rb = mk($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
              12'($urandom_range(0, 15)), 4'($urandom), $urandom);
      step(ra, rb);
    end
    repeat (3) step(IDLE, IDLE);

    // Reset with reads in flight drops them.
    step(rd_req(12'd1), rd_req(12'd2));
    assert_reset();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("flush_v_a2", {31'b0, a2.readdatavalid}, 32'h0);
      chk("flush_v_b2", {31'b0, b2.readdatavalid}, 32'h0);
      chk("flush_v_b1", {31'b0, b1.readdatavalid}, 32'h0);
    end

    // Reset pulse in the middle of clearing restarts from word 0.
    @(negedge clk);
    reset_n = 1'b1;
    repeat (102) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_cnt", 32'(dut1.r_clear_cnt), 32'd100);
    chk("mid_done", {31'b0, done1}, 32'h0);
    assert_reset();
    chk("mid_cnt0", 32'(dut1.r_clear_cnt), 32'd0);
    release_and_wait();

    // Everything written earlier must now read as zero.
    for (int i = 0; i < 16; i++) begin
      step(rd_req(12'(i)), rd_req(12'(15 - i)));
      chk("post_clr_a", a1.readdata, 32'h0);
      chk("post_clr_b", b1.readdata, 32'h0);
    end
    step(rd_req(12'hFFF), IDLE);
    chk("post_clr_fff", a1.readdata, 32'h0);
    repeat (3) step(IDLE, IDLE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/niosii_dual_port_tcm.md
NIOSII_DUAL_PORT_TCM -- requirements
Module: niosII_dual_port_tcm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8 from 8 to 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word address width; depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from accepted read to readdatavalid; legal values are 1 and 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, every word is zeroed after reset.
REQ-005 SHALL have ports clk in 1 (single clock for both ports) and reset_n in 1 (asynchronous, active-low reset).
REQ-006 SHALL have, for x in {a,b}, address_x in ADDR_WIDTH, the word address.
REQ-007 SHALL have byteenable_x in DATA_WIDTH/8, the write byte lanes.
REQ-008 SHALL have chipselect_x, read_x and write_x, each in 1 (Avalon-MM slave controls).
REQ-009 SHALL have writedata_x in DATA_WIDTH.
REQ-010 SHALL have readdata_x out DATA_WIDTH.
REQ-011 SHALL have readdatavalid_x out 1.
REQ-012 SHALL have waitrequest_x out 1.
REQ-013 SHALL have init_done out 1, high once the memory is usable.

Function
REQ-014 SHALL implement init FSM states CLEAR and READY: reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-015 In CLEAR, the block SHALL write zero to the word at clear_cnt each cycle, with clear_cnt running 0..2**ADDR_WIDTH-1, then enter READY the cycle after the last word is written.
REQ-016 init_done SHALL be 1 exactly in READY; waitrequest_a/b SHALL be 1 in CLEAR and ignore all requests.
REQ-017 A request on port x SHALL be accepted when chipselect_x & (read_x|write_x) & ~waitrequest_x.
REQ-018 An accepted write SHALL update the addressed word at the clock edge, bytes gated by byteenable_x; byteenable all-zero SHALL leave the word unchanged.
REQ-019 An accepted read SHALL return data on readdata_x with readdatavalid_x=1 for exactly one cycle, READ_LATENCY cycles after acceptance.
REQ-020 Reads SHALL be fully pipelined: one accepted read per port per cycle, in order, with no bubbles.
REQ-021 read_x and write_x both high in one accepted cycle SHALL perform the write only, with no readdatavalid_x.
REQ-022 When both ports write the same address in one cycle, port A SHALL win that cycle.
REQ-023 In that collision, waitrequest_b SHALL be 1 for that one cycle, so port B's write completes the next cycle if held (B's data ends in memory).
REQ-024 On collision, waitrequest_b SHALL be combinational from the same-cycle inputs; otherwise waitrequest_a/b SHALL be 0 in READY.
REQ-025 A read on one port that is accepted in the same cycle as a write to the same address on the other port SHALL return the old data.
REQ-026 A read and write on the same port never coincide (see REQ-021).
REQ-027 readdata_x SHALL hold its last value when readdatavalid_x=0.
REQ-028 Memory contents outside CLEAR SHALL be unaffected by reset when CLEAR_ON_RESET=0.

Reset
REQ-029 On reset_n low, asynchronously: readdata_a/b=0, readdatavalid_a/b=0, the read pipeline SHALL be flushed, init_done=0, clear_cnt=0, and waitrequest_a/b=1.
REQ-030 Deassertion of reset_n SHALL be synchronised to clk inside the block, so FSM exit is glitch-free.
REQ-031 Reset asserted mid-CLEAR SHALL restart clearing from word 0.
REQ-032 Reset asserted with reads in flight SHALL drop those reads, with no readdatavalid after reset.

Verification
REQ-033 Clear (defaults) SHALL be checked: release reset -> init_done rises after 4096 clear cycles (+sync latency); a read of addr 0xFFF then returns 0x00000000.
REQ-034 Byte write SHALL be checked: A writes 0xAABBCCDD to addr 5 with be=1111, then A writes 0x11223344 to addr 5 with be=0101 -> B read of addr 5 returns 0xAA22CC44, readdatavalid_b 1 cycle after acceptance.
REQ-035 Collision SHALL be checked: A writes 0x1 and B writes 0x2 to addr 9 in the same cycle, B held -> waitrequest_b=1 for 1 cycle; final read of addr 9 = 0x2.
REQ-036 Mixed read/write SHALL be checked: A writes 0x55 to addr 3 (old 0x0) while B reads addr 3 in the same cycle -> B gets 0x0; next B read -> 0x55.
REQ-037 Pipeline SHALL be checked with READ_LATENCY=2: 8 back-to-back B reads of addrs 0..7 -> 8 consecutive readdatavalid_b pulses starting 2 cycles after the first acceptance, with data in address order.
REQ-038 Mid-clear reset SHALL be checked: reset_n pulsed low at clear_cnt=100 -> clear_cnt=0 and init_done=0; clearing restarts and init_done rises 4096 cycles later.
